// File: rtl/fft_bf_sched_if.sv
// Bundle between the FFT butterfly scheduler, the sample RAM / twiddle ROM and the
// butterfly datapath. The scheduler is the master; fsm_state is a debug view of its FSM.
interface fft_bf_sched_if #(
  parameter int LOG2N = 3
);
  // start is a level sampled only while idle; hold is a level that only suppresses
  // issue in RUN. There is no back-pressure: rd_en/bf_enable/wr_en are one-cycle
  // strobes that the consumer must accept on the cycle they are high.
  logic             start;
  logic             hold;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             bf_enable;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [LOG2N-1:0] stage;
  logic             busy;
  logic             done;
  logic [1:0]       fsm_state;

  modport master (
    input  start, hold,
    output rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_enable,
           wr_en, wr_addr_a, wr_addr_b, stage, busy, done, fsm_state
  );

  modport slave (
    output start, hold,
    input  rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_enable,
           wr_en, wr_addr_a, wr_addr_b, stage, busy, done, fsm_state
  );
endinterface

// File: rtl/fft_bf_sched.sv
// Address/twiddle scheduler for an in-place radix-2 DIF FFT with one shared butterfly.
// Issues N/2 butterflies per stage, then drains the read->butterfly->write pipe.
module fft_bf_sched #(
  parameter int N       = 8,
  parameter int LOG2N   = 3,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  fft_bf_sched_if.master bus
);

  localparam int PIPE_LAT = MEM_LAT + BF_LAT;
  localparam int DW       = $clog2(PIPE_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q;
  logic [LOG2N-1:0] stage_q;
  logic [LOG2N-2:0] k_q;
  logic [DW-1:0]    drain_q;

  logic issue;
  logic k_last;
  logic drain_end;
  logic stage_last;

  assign issue      = (state_q == S_RUN) & ~bus.hold;
  assign k_last     = &k_q;
  assign drain_end  = (drain_q == DW'(PIPE_LAT - 1));
  assign stage_last = (stage_q == LOG2N'(LOG2N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) state_q <= S_RUN;
        end
        S_RUN: begin
          if (issue) begin
            k_q <= k_q + (LOG2N-1)'(1);
            if (k_last) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            drain_q <= '0;
            if (stage_last) begin
              state_q <= S_DONE;
              stage_q <= '0;
            end else begin
              state_q <= S_RUN;
              stage_q <= stage_q + LOG2N'(1);
            end
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The A address is k with a zero inserted at bit (LOG2N-1-stage); B sets that bit.
  logic [LOG2N-1:0] sh;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp_base;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-1:0] tw_full;

  always_comb begin
    sh       = LOG2N'(LOG2N - 1) - stage_q;
    k_ext    = {1'b0, k_q};
    span     = LOG2N'(1) << sh;
    pos      = k_ext & (span - LOG2N'(1));
    grp_base = (k_ext >> sh) << sh;
    addr_a   = (grp_base << 1) | pos;
    addr_b   = addr_a | span;
    tw_full  = pos << stage_q;
  end

  assign bus.rd_en     = issue;
  assign bus.rd_addr_a = issue ? addr_a : '0;
  assign bus.rd_addr_b = issue ? addr_b : '0;
  assign bus.tw_idx    = issue ? tw_full[LOG2N-2:0] : '0;

  // Delay lines run every cycle; idle slots carry zero addresses so the write
  // taps read back as 0 whenever wr_en is low.
  logic [PIPE_LAT-1:0] v_sr;
  logic [LOG2N-1:0]    a_sr [PIPE_LAT];
  logic [LOG2N-1:0]    b_sr [PIPE_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_sr <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        a_sr[i] <= '0;
        b_sr[i] <= '0;
      end
    end else begin
      v_sr    <= {v_sr[PIPE_LAT-2:0], issue};
      a_sr[0] <= bus.rd_addr_a;
      b_sr[0] <= bus.rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        a_sr[i] <= a_sr[i-1];
        b_sr[i] <= b_sr[i-1];
      end
    end
  end

  assign bus.bf_enable = v_sr[MEM_LAT-1];
  assign bus.wr_en     = v_sr[PIPE_LAT-1];
  assign bus.wr_addr_a = a_sr[PIPE_LAT-1];
  assign bus.wr_addr_b = b_sr[PIPE_LAT-1];

  assign bus.busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.stage     = bus.busy ? stage_q : '0;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_fft_bf_sched.sv
// Bench for fft_bf_sched: two instances (N=8 and N=16/MEM_LAT=2) compared cycle by
// cycle against a schedule model built from the stage/group/position rules.
module tb_fft_bf_sched;

  localparam int MAXC = 256;

  logic clk;
  logic rst_n;

  fft_bf_sched_if #(.LOG2N(3)) i8 ();
  fft_bf_sched_if #(.LOG2N(4)) i16 ();

  fft_bf_sched #(.N(8), .LOG2N(3), .MEM_LAT(1), .BF_LAT(1)) dut8 (
    .clk(clk), .reset_n(rst_n), .bus(i8.master)
  );

  fft_bf_sched #(.N(16), .LOG2N(4), .MEM_LAT(2), .BF_LAT(1)) dut16 (
    .clk(clk), .reset_n(rst_n), .bus(i16.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  bit          start_pat [MAXC];
  bit          hold_pat  [MAXC];
  logic [47:0] obs       [MAXC];
  int e_rd[MAXC], e_a[MAXC], e_b[MAXC], e_tw[MAXC], e_bf[MAXC];
  int e_wr[MAXC], e_wa[MAXC], e_wb[MAXC], e_st[MAXC], e_busy[MAXC], e_done[MAXC];

  // One nibble per field so traces read directly in hex.
  function automatic logic [47:0] pack(int rd, int a, int b, int tw, int bf, int wr,
                                       int wa, int wb, int st, int busy, int done);
    return {4'(rd), 4'(a), 4'(b), 4'(tw), 4'(bf), 4'(wr),
            4'(wa), 4'(wb), 4'(st), 4'(busy), 4'(done), 4'h0};
  endfunction

  function automatic logic [47:0] snap(int which);
    if (which == 8)
      return pack(int'(i8.rd_en), int'(i8.rd_addr_a), int'(i8.rd_addr_b), int'(i8.tw_idx),
                  int'(i8.bf_enable), int'(i8.wr_en), int'(i8.wr_addr_a), int'(i8.wr_addr_b),
                  int'(i8.stage), int'(i8.busy), int'(i8.done));
    return pack(int'(i16.rd_en), int'(i16.rd_addr_a), int'(i16.rd_addr_b), int'(i16.tw_idx),
                int'(i16.bf_enable), int'(i16.wr_en), int'(i16.wr_addr_a), int'(i16.wr_addr_b),
                int'(i16.stage), int'(i16.busy), int'(i16.done));
  endfunction

  function automatic logic [47:0] exp_w(int c);
    return pack(e_rd[c], e_a[c], e_b[c], e_tw[c], e_bf[c], e_wr[c],
                e_wa[c], e_wb[c], e_st[c], e_busy[c], e_done[c]);
  endfunction

  function automatic int find_done(int len);
    for (int c = 0; c < len; c++) if (obs[c][4]) return c;
    return -1;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < MAXC; c++) begin
      start_pat[c] = 1'b0; hold_pat[c] = 1'b0; obs[c] = '0;
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_bf[c] = 0; e_wr[c] = 0;
      e_wa[c] = 0; e_wb[c] = 0; e_st[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    end
  endtask

  // Walk stages, groups and positions in issue order; hold only delays the next issue.
  task automatic model_run(input int n, input int lg, input int ml, input int bl,
                           input int t0, output int done_c);
    int t, pl, span, st0, a;
    pl = ml + bl;
    t  = t0 + 1;
    for (int s = 0; s < lg; s++) begin
      st0  = t;
      span = n >> (s + 1);
      for (int g = 0; g < n / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          while (t < MAXC - 8 && hold_pat[t]) t++;
          a = g * 2 * span + p;
          e_rd[t] = 1; e_a[t] = a; e_b[t] = a + span; e_tw[t] = p << s;
          e_bf[t + ml] = 1;
          e_wr[t + pl] = 1; e_wa[t + pl] = a; e_wb[t + pl] = a + span;
          t++;
        end
      end
      t += pl;
      for (int c = st0; c < t; c++) begin
        e_st[c] = s; e_busy[c] = 1;
      end
    end
    e_done[t] = 1;
    done_c = t;
  endtask

  // Cycle c starts at a rising edge; inputs change just after it, outputs are read at the falling edge.
  task automatic run_cycles(input int which, input int len, input int rst_at, input int rst_len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      if (c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + rst_len) rst_n = 1'b1;
      if (which == 8) begin
        i8.start = start_pat[c]; i8.hold = hold_pat[c];
      end else begin
        i16.start = start_pat[c]; i16.hold = hold_pat[c];
      end
      @(negedge clk);
      obs[c] = snap(which);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i8.start = 1'b0; i8.hold = 1'b0; i16.start = 1'b0; i16.hold = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    n_tests++;
    if (snap(8) !== 48'h0 || i8.fsm_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_n8: got %h/%0d expected 0/0", snap(8), i8.fsm_state);
    end
    n_tests++;
    if (snap(16) !== 48'h0 || i16.fsm_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_n16: got %h/%0d expected 0/0", snap(16), i16.fsm_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (snap(8) !== 48'h0 || snap(16) !== 48'h0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h %h expected 0 0", snap(8), snap(16));
    end
  endtask

  task automatic test_basic();
    int dc, len;
    clear_model();
    start_pat[0] = 1'b1;
    model_run(8, 3, 1, 1, 0, dc);
    len = dc + 3;
    run_cycles(8, len, -1, 0);
    for (int c = 0; c < len; c++) begin
      n_tests++;
      if (obs[c] !== exp_w(c)) begin
        n_fail++; $display("FAIL basic_trace c%0d: got %h expected %h", c, obs[c], exp_w(c));
      end
    end
    n_tests++;
    if (find_done(len) !== 19) begin
      n_fail++; $display("FAIL basic_done_cycle: got %0d expected 19", find_done(len));
    end
  endtask

  task automatic test_hold();
    int dc, len;
    clear_model();
    start_pat[0] = 1'b1;
    hold_pat[2] = 1'b1; hold_pat[3] = 1'b1;
    model_run(8, 3, 1, 1, 0, dc);
    len = dc + 3;
    run_cycles(8, len, -1, 0);
    for (int c = 0; c < len; c++) begin
      n_tests++;
      if (obs[c] !== exp_w(c)) begin
        n_fail++; $display("FAIL hold_trace c%0d: got %h expected %h", c, obs[c], exp_w(c));
      end
    end
    n_tests++;
    if (find_done(len) !== 21) begin
      n_fail++; $display("FAIL hold_done_cycle: got %0d expected 21", find_done(len));
    end
  endtask

  task automatic test_random_hold(input int which, input int iters);
    int dc, len;
    for (int it = 0; it < iters; it++) begin
      clear_model();
      start_pat[0] = 1'b1;
      for (int c = 1; c < 80; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
      if (which == 8) model_run(8, 3, 1, 1, 0, dc);
      else            model_run(16, 4, 2, 1, 0, dc);
      len = dc + 3;
      run_cycles(which, len, -1, 0);
      for (int c = 0; c < len; c++) begin
        n_tests++;
        if (obs[c] !== exp_w(c)) begin
          n_fail++;
          $display("FAIL random_hold_n%0d it%0d c%0d: got %h expected %h", which, it, c, obs[c], exp_w(c));
        end
      end
      n_tests++;
      if (find_done(len) !== dc) begin
        n_fail++; $display("FAIL random_done_n%0d: got %0d expected %0d", which, find_done(len), dc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc0, dc1, len;
    clear_model();
    start_pat[0] = 1'b1; start_pat[5] = 1'b1; start_pat[10] = 1'b1; start_pat[20] = 1'b1;
    model_run(8, 3, 1, 1, 0, dc0);
    model_run(8, 3, 1, 1, 20, dc1);
    len = dc1 + 3;
    run_cycles(8, len, -1, 0);
    for (int c = 0; c < len; c++) begin
      n_tests++;
      if (obs[c] !== exp_w(c)) begin
        n_fail++; $display("FAIL back_to_back c%0d: got %h expected %h", c, obs[c], exp_w(c));
      end
    end
    n_tests++;
    if (obs[21][44] !== 1'b1 || obs[20][44] !== 1'b0) begin
      n_fail++; $display("FAIL restart_first_rd: got rd c20=%b c21=%b expected 0 1", obs[20][44], obs[21][44]);
    end
  endtask

  task automatic test_reset_mid();
    int dc, len;
    clear_model();
    start_pat[0] = 1'b1;
    model_run(8, 3, 1, 1, 0, dc);
    for (int c = 8; c < MAXC; c++) begin
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_bf[c] = 0; e_wr[c] = 0;
      e_wa[c] = 0; e_wb[c] = 0; e_st[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    end
    len = 30;
    run_cycles(8, len, 8, 2);
    for (int c = 0; c < len; c++) begin
      n_tests++;
      if (obs[c] !== exp_w(c)) begin
        n_fail++; $display("FAIL reset_mid c%0d: got %h expected %h", c, obs[c], exp_w(c));
      end
    end
    clear_model();
    start_pat[0] = 1'b1;
    model_run(8, 3, 1, 1, 0, dc);
    len = dc + 3;
    run_cycles(8, len, -1, 0);
    for (int c = 0; c < len; c++) begin
      n_tests++;
      if (obs[c] !== exp_w(c)) begin
        n_fail++; $display("FAIL after_reset c%0d: got %h expected %h", c, obs[c], exp_w(c));
      end
    end
  endtask

  task automatic test_n16();
    int dc, len;
    clear_model();
    start_pat[0] = 1'b1;
    model_run(16, 4, 2, 1, 0, dc);
    len = dc + 3;
    run_cycles(16, len, -1, 0);
    for (int c = 0; c < len; c++) begin
      n_tests++;
      if (obs[c] !== exp_w(c)) begin
        n_fail++; $display("FAIL n16_trace c%0d: got %h expected %h", c, obs[c], exp_w(c));
      end
    end
    n_tests++;
    if (find_done(len) !== 45) begin
      n_fail++; $display("FAIL n16_done_cycle: got %0d expected 45", find_done(len));
    end
    n_tests++;
    if (obs[3][28] !== 1'b1 || obs[4][24] !== 1'b1 || obs[2][28] !== 1'b0) begin
      n_fail++; $display("FAIL n16_latency: got bf c2=%b c3=%b wr c4=%b expected 0 1 1",
                         obs[2][28], obs[3][28], obs[4][24]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    i8.start = 1'b0; i8.hold = 1'b0; i16.start = 1'b0; i16.hold = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_random_hold(8, 4);
    test_back_to_back();
    test_reset_mid();
    test_n16();
    test_random_hold(16, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
